// File: rtl/linalg_pkg.sv
// Shared constants and helpers for the linear-algebra streaming blocks.
package linalg_pkg;

  localparam int WORD_W = 32;

  // Index width for a dimension of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    GET_INPUT = 1'b0,
    PUT_ELEM  = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/mat_unpack.sv
// Captures an M x P matrix of 32-bit words in one handshake and streams the
// elements out one per handshake in row-major order with their indices.
//
// state     | meaning
// GET_INPUT | waiting for input_z; input_z_ack high
// PUT_ELEM  | presenting buffer[row][col]; output_e_stb high
module mat_unpack
  import linalg_pkg::*;
#(
  parameter int M = 8,
  parameter int P = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [M-1:0][P-1:0][WORD_W-1:0]    input_z,
  input  logic                               input_z_stb,
  output logic                               input_z_ack,
  output logic [WORD_W-1:0]                  output_e,
  output logic [idx_w(M)-1:0]                output_e_row,
  output logic [idx_w(P)-1:0]                output_e_col,
  output logic                               output_e_last,
  output logic                               output_e_stb,
  input  logic                               output_e_ack
);

  localparam int RW = idx_w(M);
  localparam int CW = idx_w(P);

  unpack_state_t                     r_state;
  unpack_state_t                     w_next_state;
  logic [M-1:0][P-1:0][WORD_W-1:0]   r_buf;
  logic [RW-1:0]                     r_row;
  logic [CW-1:0]                     r_col;
  logic                              w_in_xfer;
  logic                              w_out_xfer;
  logic                              w_row_end;
  logic                              w_col_end;
  logic [WORD_W-1:0]                 w_elem;

  assign w_in_xfer  = input_z_stb & input_z_ack;
  assign w_out_xfer = output_e_stb & output_e_ack;
  assign w_row_end  = (r_row == RW'(M - 1));
  assign w_col_end  = (r_col == CW'(P - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= GET_INPUT;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      GET_INPUT: if (input_z_stb) w_next_state = PUT_ELEM;
      PUT_ELEM:  if (output_e_ack && w_row_end && w_col_end) w_next_state = GET_INPUT;
      default:   w_next_state = GET_INPUT;
    endcase
  end

  always_comb begin
    input_z_ack  = (r_state == GET_INPUT);
    output_e_stb = (r_state == PUT_ELEM);
  end

  // Buffer is write-only on capture so it needs no reset.
  always_ff @(posedge clk) begin
    if (rst && w_in_xfer) r_buf <= input_z;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_in_xfer) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_out_xfer) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Explicit mux keeps index widths independent of the buffer dimensions.
  always_comb begin
    w_elem = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < P; j++) begin
        if (r_row == RW'(i) && r_col == CW'(j)) w_elem = r_buf[i][j];
      end
    end
  end

  assign output_e      = w_elem;
  assign output_e_row  = r_row;
  assign output_e_col  = r_col;
  assign output_e_last = w_row_end & w_col_end;

endmodule
